sprite_line_buffer: RTL and testbench



---
 rtl/sprite_lb_pkg.sv | 26 ++
 rtl/lb_bank_ram.sv | 37 +++
 rtl/sprite_line_buffer.sv | 120 ++++++++++++
 tb/tb_sprite_line_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_lb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_lb_pkg : shared types/constants for the sprite line buffer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sprite_lb_pkg;

  localparam int XW_DEF = 8;
  localparam int CW_DEF = 8;

  localparam logic [3:0] PEN_TRANSP = 4'h0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              bank;
    logic [XW_DEF-1:0] x;
    logic [CW_DEF-1:0] color;
  } wpipe_t;

endpackage
`default_nettype wire

// File: rtl/lb_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lb_bank_ram : one line bank, 1 read + 1 write port plus a clear port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lb_bank_ram
  import sprite_lb_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic [XW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          clr_en,
  input  logic [XW-1:0] clr_addr
);

  logic [CW-1:0] mem_q [0:(2**XW)-1];

  assign rd_data = mem_q[rd_addr];

  // Clear is issued last so it wins an address collision with a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_line_buffer : double-buffered sprite line, clear-on-read      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_line_buffer
  import sprite_lb_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          line_start,
  input  logic          active,
  input  logic [XW-1:0] rd_x,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [CW-1:0] wr_color,
  output logic [CW-1:0] pix_index,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [XW-1:0] cnt_q, cnt_d;
  logic          wbank_q, wbank_d;
  wpipe_t        wp_q, wp_d;
  logic [3:0]    exist_pen_q, exist_pen_d;
  logic [CW-1:0] pix_index_q, pix_index_d;

  logic               run;
  logic               pipe_load;
  logic               s2_we;
  logic               hazard;
  logic               rd_en;
  logic [1:0][CW-1:0] bank_rd_data;

  assign run       = (state_q == RUN);
  assign pipe_load = run & wr_valid & (wr_color[3:0] != PEN_TRANSP);
  assign s2_we     = wp_q.valid & (exist_pen_q == PEN_TRANSP);
  // S2 lands at the same edge S1 samples memory, so take S2's colour instead.
  assign hazard    = s2_we & (wp_q.bank == wbank_q) & (wp_q.x == wr_x);
  assign rd_en     = run & ce_pix & active;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wbank_d     = wbank_q;
    wp_d        = '0;
    exist_pen_d = '0;
    pix_index_d = pix_index_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (line_start) begin
          wbank_d = ~wbank_q;
        end
        if (pipe_load) begin
          wp_d.valid  = 1'b1;
          wp_d.bank   = wbank_q;
          wp_d.x      = wr_x;
          wp_d.color  = wr_color;
          exist_pen_d = hazard ? wp_q.color[3:0] : bank_rd_data[wbank_q][3:0];
        end
        if (ce_pix) begin
          pix_index_d = active ? bank_rd_data[~wbank_q] : '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      wbank_q     <= 1'b0;
      wp_q        <= '0;
      exist_pen_q <= '0;
      pix_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbank_q     <= wbank_d;
      wp_q        <= wp_d;
      exist_pen_q <= exist_pen_d;
      pix_index_q <= pix_index_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK = 1'(b);
    lb_bank_ram #(
      .XW(XW),
      .CW(CW)
    ) u_ram (
      .clk      (clk),
      .rd_addr  ((wbank_q == BANK) ? wr_x : rd_x),
      .rd_data  (bank_rd_data[b]),
      .wr_en    (s2_we & (wp_q.bank == BANK)),
      .wr_addr  (wp_q.x),
      .wr_data  (wp_q.color),
      .clr_en   (!run | (rd_en & (wbank_q != BANK))),
      .clr_addr (run ? rd_x : cnt_q)
    );
  end

  assign wr_ready  = run;
  assign busy      = !run;
  assign pix_index = pix_index_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_line_buffer : directed bench for sprite_line_buffer        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sprite_line_buffer;

  localparam int XW = 8;
  localparam int CW = 8;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          ce_pix     = 1'b0;
  logic          line_start = 1'b0;
  logic          active     = 1'b0;
  logic [XW-1:0] rd_x       = '0;
  logic          wr_valid   = 1'b0;
  logic [XW-1:0] wr_x       = '0;
  logic [CW-1:0] wr_color   = '0;
  logic          wr_ready;
  logic [CW-1:0] pix_index;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sprite_line_buffer #(
    .XW(XW),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .line_start (line_start),
    .active     (active),
    .rd_x       (rd_x),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_color   (wr_color),
    .pix_index  (pix_index),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input logic [XW-1:0] x, input logic [CW-1:0] c);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_color = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_px(input logic [XW-1:0] x);
    ce_pix = 1'b1;
    active = 1'b1;
    rd_x   = x;
    tick();
    ce_pix = 1'b0;
    active = 1'b0;
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    check_val("rst_pix", pix_index, 8'h00);
    check_val("rst_busy", busy, 1'b1);
    check_val("rst_wr_ready", wr_ready, 1'b0);

    // Inputs are hammered during the sweep; all must be ignored.
    ce_pix = 1'b1; active = 1'b1; rd_x = 8'd3; line_start = 1'b1;
    wr_valid = 1'b1; wr_x = 8'd3; wr_color = 8'h77;
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      check_val("clear_busy", busy, 1'b1);
      check_val("clear_rdy_pix", {wr_ready, pix_index}, 9'h000);
      tick();
    end
    ce_pix = 1'b0; active = 1'b0; line_start = 1'b0; wr_valid = 1'b0;
    check_val("run_busy", busy, 1'b0);
    check_val("run_wr_ready", wr_ready, 1'b1);

    rd_px(8'd77);
    check_val("post_clear_rd77", pix_index, 8'h00);
    swap();
    rd_px(8'd3);
    check_val("clear_ignored_wr", pix_index, 8'h00);
    swap();

    // First opaque write wins.
    wr_px(8'd10, 8'h35);
    wr_px(8'd10, 8'h47);
    tick();
    swap();
    rd_px(8'd10);
    check_val("first_wins_x10", pix_index, 8'h35);
    tick();
    check_val("hold_no_ce", pix_index, 8'h35);
    ce_pix = 1'b1; active = 1'b0; rd_x = 8'd10;
    tick();
    ce_pix = 1'b0;
    check_val("inactive_zero", pix_index, 8'h00);
    rd_px(8'd10);
    check_val("clear_on_read_x10", pix_index, 8'h00);
    swap();
    swap();
    rd_px(8'd10);
    check_val("next_line_x10", pix_index, 8'h00);

    // Transparent pen is dropped, so the later opaque write lands.
    wr_px(8'd20, 8'h50);
    wr_px(8'd20, 8'h23);
    tick();
    swap();
    rd_px(8'd20);
    check_val("transp_drop_x20", pix_index, 8'h23);

    // Write accepted on the swap edge belongs to the old bank.
    wr_valid = 1'b1; wr_x = 8'd5; wr_color = 8'h1A; line_start = 1'b1;
    tick();
    wr_valid = 1'b0; line_start = 1'b0;
    tick();
    rd_px(8'd5);
    check_val("swap_edge_wr_x5", pix_index, 8'h1A);

    // Back-to-back same-x writes exercise forwarding.
    wr_px(8'd255, 8'h0F);
    wr_px(8'd255, 8'h0E);
    tick();
    swap();
    rd_px(8'd255);
    check_val("fwd_x255", pix_index, 8'h0F);
    rd_px(8'd0);
    check_val("no_alias_x0", pix_index, 8'h00);

    // Concurrent write (x=255) and read (x=0) on opposite banks.
    wr_valid = 1'b1; wr_x = 8'd255; wr_color = 8'h3C;
    ce_pix = 1'b1; active = 1'b1; rd_x = 8'd0;
    tick();
    wr_valid = 1'b0; ce_pix = 1'b0; active = 1'b0;
    check_val("concurrent_rd_x0", pix_index, 8'h00);
    tick();
    swap();
    rd_px(8'd255);
    check_val("concurrent_wr_x255", pix_index, 8'h3C);
    rd_px(8'd0);
    check_val("concurrent_x0_again", pix_index, 8'h00);

    // Mid-line reset wipes both banks via a fresh sweep.
    wr_px(8'd30, 8'h61);
    wr_px(8'd31, 8'h44);
    tick();
    swap();
    wr_px(8'd30, 8'h62);
    tick();
    rd_px(8'd31);
    check_val("pre_reset_x31", pix_index, 8'h44);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_pix", pix_index, 8'h00);
    check_val("async_rst_busy", busy, 1'b1);
    check_val("async_rst_wr_ready", wr_ready, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (255) tick();
    check_val("resweep_busy_255", busy, 1'b1);
    tick();
    check_val("resweep_done", busy, 1'b0);
    rd_px(8'd30);
    check_val("reset_x30_bank1", pix_index, 8'h00);
    swap();
    rd_px(8'd30);
    check_val("reset_x30_bank0", pix_index, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
